ifetch_queue: RTL

//  Parametrised instruction fetch unit with prefetch queue. Next generation of the single-register fetch stage.

---
 rtl/ifetch_queue_pkg.sv | 10 +
 rtl/ifetch_queue_fifo.sv | 62 ++++++
 rtl/ifetch_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction fetch queue.
package ifetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO for fetched {address, instruction} entries; flush dominates push.
module ifetch_queue_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + PW'(1);
      end
      if (pop_i) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with prefetch queue and branch redirect.
// Optional saturating perf counters when IFETCH_PERF_EN is defined.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int ADDR     = 16,
  parameter int WORD     = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_o,
  output logic [ADDR-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [WORD-1:0] mem_data_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] branch_addr_i,
  input  logic            stall_i,
`ifdef IFETCH_PERF_EN
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_flush_o,
`endif
  output logic            inst_valid_o,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] inst_addr_o
);

  localparam int EW = ADDR + WORD;
  localparam int CW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [ADDR-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [EW-1:0]   head;
  logic [CW-1:0]   count;
  logic [CW:0]     count_next;
  logic            push, pop, room;

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o && !stall_i && !branch_i;
  assign push         = (state_q == ST_REQ) && mem_ack_i && !branch_i;
  // Occupancy after this cycle's push/pop; no request is outstanding once it is decided.
  assign count_next   = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign room         = count_next < (CW+1)'(DEPTH);

  ifetch_queue_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({addr_q, mem_data_i}),
    .pop_i   (pop),
    .flush_i (branch_i),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (branch_i) begin
          pc_d = branch_addr_i;
        end else if (room) begin
          state_d = ST_REQ;
          addr_d  = pc_q;
        end
      end
      ST_REQ: begin
        if (branch_i) begin
          pc_d = branch_addr_i;
          if (mem_ack_i) addr_d = branch_addr_i;
          else           state_d = ST_DROP;
        end else if (mem_ack_i) begin
          pc_d = pc_q + ADDR'(1);
          if (room) addr_d = pc_q + ADDR'(1);
          else      state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (branch_i)  pc_d = branch_addr_i;
        if (mem_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR'(RESET_PC);
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_req_o   = (state_q != ST_IDLE);
  assign mem_addr_o  = addr_q;
  assign inst_o      = inst_valid_o ? head[WORD-1:0] : '0;
  assign inst_addr_o = inst_valid_o ? head[EW-1:WORD] : '0;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_q, fetch_d, flush_q, flush_d;

  always_comb begin
    fetch_d = fetch_q;
    flush_d = flush_q;
    if (push && fetch_q != '1)     fetch_d = fetch_q + 32'd1;
    if (branch_i && flush_q != '1) flush_d = flush_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      flush_q <= flush_d;
    end
  end

  assign perf_fetch_o = fetch_q;
  assign perf_flush_o = flush_q;
`endif

endmodule
